// File: rtl/weight_ram_sched_if.sv
`default_nettype none
// ============================================================================
//  weight_ram_sched_if
//  Requester, init-control and RAM-side signals of the weight RAM scheduler.
//  Revision: 1.0
// ============================================================================
interface weight_ram_sched_if #(
   parameter int N = 10
);
   logic                  start_init;
   logic                  init_done;
   logic                  rd_req;
   logic [6:0]            rd_addr;
   logic                  rd_gnt;
   logic                  rd_valid;
   logic [0:N-1][9:0]     rd_data;
   logic                  wr_req;
   logic [6:0]            wr_addr;
   logic [0:N-1][9:0]     wr_data;
   logic                  wr_gnt;
   logic                  err;
   logic                  busy;
   logic                  ram_In;
   logic                  ram_WE;
   logic [6:0]            ram_Address;
   logic [0:N-1][9:0]     ram_D;
   logic [0:N-1][9:0]     ram_Q;

   // Environment side: requesters, init controller and the RAM itself
   modport master (
      output start_init, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_Q,
      input  init_done, rd_gnt, rd_valid, rd_data, wr_gnt, err, busy,
             ram_In, ram_WE, ram_Address, ram_D
   );

   modport slave (
      input  start_init, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_Q,
      output init_done, rd_gnt, rd_valid, rd_data, wr_gnt, err, busy,
             ram_In, ram_WE, ram_Address, ram_D
   );
endinterface
`default_nettype wire

// File: rtl/weight_ram_sched.sv
`default_nettype none
// ============================================================================
//  weight_ram_sched
//  Sequences the weight RAM randomisation pass, then arbitrates the N-word
//  burst port between the forward-pass reader and the update writer.
//  Option: define WEIGHT_SCHED_RR_EN for round-robin instead of write priority.
//  Revision: 1.0
// ============================================================================
module weight_ram_sched #(
   parameter int N           = 10,
   parameter int DEPTH       = 65,
   parameter int INIT_CYCLES = 66
) (
   input wire               Clock,
   input wire               Rst,
   weight_ram_sched_if.slave bus
);

   localparam int         CW         = $clog2(INIT_CYCLES + 1);
   localparam logic [6:0] c_max_base = 7'(DEPTH - N);

   typedef logic [0:N-1][9:0] burst_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_RD_DONE  = 3'd4,
      S_WR_ISSUE = 3'd5
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_init_done, w_init_done_nxt;
   logic          r_rd_gnt, w_rd_gnt_nxt;
   logic          r_rd_valid, w_rd_valid_nxt;
   logic          r_wr_gnt, w_wr_gnt_nxt;
   logic          r_err, w_err_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_ram_in, w_ram_in_nxt;
   logic          r_ram_we, w_ram_we_nxt;
   logic [6:0]    r_ram_addr, w_ram_addr_nxt;
   burst_t        r_ram_d, w_ram_d_nxt;
   burst_t        r_rd_data, w_rd_data_nxt;

   logic          w_pick_wr;
   logic          w_rd_legal;
   logic          w_wr_legal;

   assign w_rd_legal = (bus.rd_addr <= c_max_base);
   assign w_wr_legal = (bus.wr_addr <= c_max_base);

`ifdef WEIGHT_SCHED_RR_EN
   // High when the reader should win a tie, i.e. the last grant went to the writer
   logic r_prio_rd;

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_prio_rd <= 1'b0;
      end else if (w_rd_gnt_nxt || w_wr_gnt_nxt) begin
         r_prio_rd <= w_wr_gnt_nxt;
      end
   end

   assign w_pick_wr = bus.wr_req && (!bus.rd_req || !r_prio_rd);
`else
   assign w_pick_wr = bus.wr_req;
`endif

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_rd_gnt    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_wr_gnt    <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_ram_in    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_d     <= '0;
         r_rd_data   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_done <= w_init_done_nxt;
         r_rd_gnt    <= w_rd_gnt_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_wr_gnt    <= w_wr_gnt_nxt;
         r_err       <= w_err_nxt;
         r_busy      <= w_busy_nxt;
         r_ram_in    <= w_ram_in_nxt;
         r_ram_we    <= w_ram_we_nxt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_d     <= w_ram_d_nxt;
         r_rd_data   <= w_rd_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_init_done_nxt = r_init_done;
      w_rd_gnt_nxt    = 1'b0;
      w_rd_valid_nxt  = 1'b0;
      w_wr_gnt_nxt    = 1'b0;
      w_err_nxt       = 1'b0;
      w_ram_in_nxt    = 1'b0;
      w_ram_we_nxt    = 1'b0;
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_d_nxt     = r_ram_d;
      w_rd_data_nxt   = r_rd_data;

      case (r_state)
         // RD_DONE arbitrates like IDLE so reads can issue every third cycle
         S_IDLE, S_RD_DONE: begin
            w_state_nxt = S_IDLE;
            if (bus.start_init) begin
               w_state_nxt     = S_INIT;
               w_cnt_nxt       = '0;
               w_init_done_nxt = 1'b0;
               w_ram_in_nxt    = 1'b1;
            end else if (r_init_done) begin
               if (w_pick_wr) begin
                  w_state_nxt  = S_WR_ISSUE;
                  w_wr_gnt_nxt = 1'b1;
                  if (w_wr_legal) begin
                     w_ram_we_nxt   = 1'b1;
                     w_ram_addr_nxt = bus.wr_addr;
                     w_ram_d_nxt    = bus.wr_data;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end else if (bus.rd_req) begin
                  w_state_nxt  = S_RD_ISSUE;
                  w_rd_gnt_nxt = 1'b1;
                  if (w_rd_legal) begin
                     w_ram_addr_nxt = bus.rd_addr;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
         end
         S_INIT: begin
            if (r_cnt == CW'(INIT_CYCLES - 1)) begin
               w_state_nxt     = S_IDLE;
               w_init_done_nxt = 1'b1;
            end else begin
               w_cnt_nxt    = r_cnt + CW'(1);
               w_ram_in_nxt = 1'b1;
            end
         end
         // An out-of-range read never touched the RAM, so skip the data phase
         S_RD_ISSUE: w_state_nxt = r_err ? S_IDLE : S_RD_WAIT;
         S_RD_WAIT: begin
            w_state_nxt    = S_RD_DONE;
            w_rd_data_nxt  = bus.ram_Q;
            w_rd_valid_nxt = 1'b1;
         end
         S_WR_ISSUE: w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign bus.init_done   = r_init_done;
   assign bus.rd_gnt      = r_rd_gnt;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_data     = r_rd_data;
   assign bus.wr_gnt      = r_wr_gnt;
   assign bus.err         = r_err;
   assign bus.busy        = r_busy;
   assign bus.ram_In      = r_ram_in;
   assign bus.ram_WE      = r_ram_we;
   assign bus.ram_Address = r_ram_addr;
   assign bus.ram_D       = r_ram_d;

endmodule
`default_nettype wire

// File: tb/tb_weight_ram_sched.sv
`default_nettype none
// ============================================================================
//  tb_weight_ram_sched
//  Randomised scoreboard bench for weight_ram_sched with a behavioural RAM.
//  Revision: 1.0
// ============================================================================
module tb_weight_ram_sched;

   localparam int N           = 10;
   localparam int DEPTH       = 65;
   localparam int INIT_CYCLES = 66;

   typedef logic [0:N-1][9:0] burst_t;

   typedef struct {
      bit         is_wr;
      bit         err;
      logic [6:0] addr;
      burst_t     data;
   } gnt_t;

   logic Clock = 1'b0;
   logic Rst   = 1'b1;

   weight_ram_sched_if #(.N(N)) bus ();

   weight_ram_sched #(
      .N           (N),
      .DEPTH       (DEPTH),
      .INIT_CYCLES (INIT_CYCLES)
   ) dut (
      .Clock (Clock),
      .Rst   (Rst),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc      = 0;
   gnt_t       exp_gnt_q[$];
   burst_t     exp_rd_q[$];
   int         rd_gnt_cyc_q[$];
   logic [9:0] shadow [0:DEPTH-1];
   logic [6:0] exp_ram_addr = '0;
   bit         last_wr      = 1'b0;

   function automatic logic [9:0] init_word(input int k);
      return 10'((k * 37 + 5) ^ 'h2A5);
   endfunction

   function automatic burst_t shadow_burst(input logic [6:0] a);
      burst_t b;
      for (int i = 0; i < N; i++) b[i] = shadow[int'(a) + i];
      return b;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_msg(input string name, input string what);
      n_checks++;
      n_errors++;
      $display("FAIL %s %s", name, what);
   endtask

   // Behavioural weight RAM: randomisation fills a known pattern, bursts of N words
   logic [9:0] ram_mem [0:DEPTH-1];
   always @(posedge Clock) begin
      if (bus.ram_In) begin
         for (int k = 0; k < DEPTH; k++) ram_mem[k] = init_word(k);
      end else if (bus.ram_WE) begin
         for (int i = 0; i < N; i++)
            if (int'(bus.ram_Address) + i < DEPTH) ram_mem[int'(bus.ram_Address) + i] = bus.ram_D[i];
      end
      for (int i = 0; i < N; i++)
         bus.ram_Q[i] <= (int'(bus.ram_Address) + i < DEPTH) ? ram_mem[int'(bus.ram_Address) + i] : 10'd0;
   end

   // Monitor: pops expected grants / read data whenever the DUT presents them
   always @(negedge Clock) begin
      gnt_t   e;
      burst_t d;
      int     g;
      cyc++;
      if (!Rst) begin
         if (bus.rd_gnt && bus.wr_gnt) begin
            fail_msg("dual_gnt", "rd_gnt and wr_gnt both high");
         end else if (bus.rd_gnt || bus.wr_gnt) begin
            if (exp_gnt_q.size() == 0) begin
               fail_msg("unexpected_gnt", "grant with nothing expected");
            end else begin
               e = exp_gnt_q.pop_front();
               chk("gnt_kind_wr", 128'(bus.wr_gnt), 128'(e.is_wr));
               chk("gnt_err", 128'(bus.err), 128'(e.err));
               if (!e.err) exp_ram_addr = e.addr;
               chk("ram_address", 128'(bus.ram_Address), 128'(exp_ram_addr));
               chk("ram_we", 128'(bus.ram_WE), 128'(e.is_wr && !e.err));
               chk("busy_on_gnt", 128'(bus.busy), 128'(1));
               if (e.is_wr && !e.err) chk("ram_d", 128'(bus.ram_D), 128'(e.data));
               if (!e.is_wr && !e.err) rd_gnt_cyc_q.push_back(cyc);
            end
         end else begin
            chk("we_without_gnt", 128'(bus.ram_WE), 128'(0));
            chk("err_without_gnt", 128'(bus.err), 128'(0));
         end
         if (bus.rd_valid) begin
            if (exp_rd_q.size() == 0 || rd_gnt_cyc_q.size() == 0) begin
               fail_msg("unexpected_rd_valid", "rd_valid with no read outstanding");
            end else begin
               d = exp_rd_q.pop_front();
               g = rd_gnt_cyc_q.pop_front();
               chk("rd_data", 128'(bus.rd_data), 128'(d));
               chk("rd_latency", 128'(cyc - g), 128'(2));
            end
         end
      end
   end

   task automatic expect_op(input bit is_wr, input logic [6:0] addr, input burst_t data);
      gnt_t e;
      e.is_wr = is_wr;
      e.err   = (int'(addr) > DEPTH - N);
      e.addr  = addr;
      e.data  = data;
      exp_gnt_q.push_back(e);
      if (!e.err) begin
         if (is_wr) for (int i = 0; i < N; i++) shadow[int'(addr) + i] = data[i];
         else       exp_rd_q.push_back(shadow_burst(addr));
      end
      last_wr = is_wr;
   endtask

   task automatic wait_gnt(input string name);
      bit got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge Clock);
         got = bus.rd_gnt || bus.wr_gnt;
      end
      if (!got) fail_msg(name, "no grant within 40 cycles");
   endtask

   task automatic do_op(input bit is_wr, input logic [6:0] addr, input burst_t data);
      expect_op(is_wr, addr, data);
      @(posedge Clock); #1;
      if (is_wr) begin
         bus.wr_addr = addr;
         bus.wr_data = data;
         bus.wr_req  = 1'b1;
      end else begin
         bus.rd_addr = addr;
         bus.rd_req  = 1'b1;
      end
      wait_gnt(is_wr ? "op_wr_gnt" : "op_rd_gnt");
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
   endtask

   task automatic pulse_init;
      @(posedge Clock); #1;
      bus.start_init = 1'b1;
      for (int k = 0; k < DEPTH; k++) shadow[k] = init_word(k);
      @(posedge Clock); #1;
      bus.start_init = 1'b0;
   endtask

   task automatic do_init;
      int n = 0;
      pulse_init();
      chk("init_done_cleared", 128'(bus.init_done), 128'(0));
      while (bus.ram_In && n < 200) begin
         n++;
         @(posedge Clock); #1;
      end
      chk("ram_in_cycles", 128'(n), 128'(INIT_CYCLES));
      chk("init_done_set", 128'(bus.init_done), 128'(1));
      chk("busy_after_init", 128'(bus.busy), 128'(0));
   endtask

   task automatic apply_reset;
      Rst = 1'b1;
      @(posedge Clock); #1;
      Rst = 1'b0;
      exp_ram_addr = '0;
      last_wr      = 1'b0;
   endtask

   // Both requesters held high; grant order and spacing from the arbitration rule
   task automatic both_held(input int n, input logic [6:0] ra, input logic [6:0] wa, input burst_t wd);
      bit kinds[$];
      bit wr_turn;
      int got = 0, c = 0, prev_c = 0;
`ifdef WEIGHT_SCHED_RR_EN
      wr_turn = !last_wr;
`else
      wr_turn = 1'b1;
`endif
      for (int g = 0; g < n; g++) begin
         kinds.push_back(wr_turn);
         expect_op(wr_turn, wr_turn ? wa : ra, wd);
`ifdef WEIGHT_SCHED_RR_EN
         wr_turn = !wr_turn;
`endif
      end
      @(posedge Clock); #1;
      bus.rd_addr = ra;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_req  = 1'b1;
      bus.wr_req  = 1'b1;
      while (got < n && c < 100) begin
         @(negedge Clock);
         c++;
         if (bus.rd_gnt || bus.wr_gnt) begin
            if (got > 0) chk("grant_spacing", 128'(c - prev_c), 128'(kinds[got-1] ? 2 : 3));
            prev_c = c;
            got++;
         end
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      if (got < n) fail_msg("both_held", "grant count short of expected");
   endtask

   initial begin
      burst_t     d;
      logic [6:0] a;
      int         r;
      bit         saw;

      bus.start_init = 1'b0;
      bus.rd_req     = 1'b0;
      bus.rd_addr    = '0;
      bus.wr_req     = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      for (int k = 0; k < DEPTH; k++) shadow[k] = '0;

      repeat (3) @(posedge Clock);
      #1 Rst = 1'b0;
      chk("rst_init_done", 128'(bus.init_done), 128'(0));
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_ram_in", 128'(bus.ram_In), 128'(0));
      chk("rst_ram_addr", 128'(bus.ram_Address), 128'(0));
      chk("rst_rd_data", 128'(bus.rd_data), 128'(0));
      chk("rst_gnts", 128'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.err}), 128'(0));

      // Read requested before any randomisation pass: must wait for init_done
      bus.rd_addr = 7'd12;
      bus.rd_req  = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge Clock);
         if (bus.rd_gnt || bus.err) saw = 1'b1;
      end
      chk("pre_init_no_gnt", 128'(saw), 128'(0));
      do_init();
      expect_op(1'b0, 7'd12, '0);
      wait_gnt("post_init_rd_gnt");
      bus.rd_req = 1'b0;

      for (int i = 0; i < N; i++) d[i] = 10'(i + 100);
      do_op(1'b1, 7'd20, d);
      do_op(1'b0, 7'd20, '0);
      do_op(1'b0, 7'd56, '0);
      do_op(1'b0, 7'd55, '0);
      do_op(1'b1, 7'd56, d);
      do_op(1'b1, 7'd55, d);
      do_op(1'b0, 7'd46, '0);

      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = 7'($urandom_range(56, 127));
         else if (r == 1) a = 7'd55;
         else             a = 7'($urandom_range(0, 55));
         for (int i = 0; i < N; i++) d[i] = 10'($urandom_range(0, 1023));
         do_op(1'($urandom_range(0, 1)), a, d);
         repeat ($urandom_range(0, 3)) @(posedge Clock);
      end

      do_op(1'b0, 7'd5, '0);
      for (int i = 0; i < N; i++) d[i] = 10'(i * 7 + 3);
      both_held(4, 7'd40, 7'd30, d);
      repeat (12) @(posedge Clock);

      // Reset while a read is in RD_WAIT: its data must never appear
      do_op(1'b0, 7'd10, '0);
      @(posedge Clock); #1;
      Rst = 1'b1;
      exp_rd_q.delete();
      rd_gnt_cyc_q.delete();
      @(posedge Clock); #1;
      Rst = 1'b0;
      exp_ram_addr = '0;
      last_wr      = 1'b0;
      chk("rdwait_rst_init_done", 128'(bus.init_done), 128'(0));
      chk("rdwait_rst_busy", 128'(bus.busy), 128'(0));
      chk("rdwait_rst_valid", 128'(bus.rd_valid), 128'(0));
      repeat (4) @(posedge Clock);

      // Reset in the middle of the randomisation pass
      pulse_init();
      repeat (10) @(posedge Clock);
      #1 Rst = 1'b1;
      @(posedge Clock); #1;
      chk("midinit_rst_ram_in", 128'(bus.ram_In), 128'(0));
      chk("midinit_rst_init_done", 128'(bus.init_done), 128'(0));
      Rst = 1'b0;
      exp_ram_addr = '0;
      last_wr      = 1'b0;

      do_init();
      for (int i = 0; i < N; i++) d[i] = 10'($urandom_range(0, 1023));
      do_op(1'b1, 7'd0, d);
      do_op(1'b0, 7'd0, '0);
      do_op(1'b0, 7'd33, '0);

      repeat (20) @(posedge Clock);
      #1;
      chk("gnt_queue_drained", 128'(exp_gnt_q.size()), 128'(0));
      chk("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));
      chk("final_busy", 128'(bus.busy), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Unused helper to keep apply_reset reachable if stimulus is extended
   initial begin
      if (0) apply_reset();
   end

endmodule
`default_nettype wire
